multi_ctrl: RTL and testbench

MULTI_CTRL -- requirements
Module: multi_ctrl

---
 rtl/multi_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_multi_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ctrl.sv
// multi_ctrl: Moore control FSM for a multi-cycle MIPS-style datapath.
//
// Decodes the instruction register fields (op, funct) and steps through
// fetch / decode / execute / memory / write-back states, driving the
// datapath enables and mux selects from the current state.
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset (forces IDLE)
//   op[5:0]             instruction bits [31:26]
//   funct[5:0]          instruction bits [5:0]
//   IRWrite, MemRead, MemWrite, IorD, MemtoReg, RegDst, RegWrite,
//   ALUSrcA, PCWrite, PCWriteCond   1-bit datapath enables/selects
//   ALUSrcB[1:0], PCSource[1:0]     datapath mux selects
//   ALUCtrl[2:0]        000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   illegal             one-cycle pulse when DECODE sees an unsupported op/funct
//   state[3:0]          current state (debug)
module multi_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUCtrl,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        RWB    = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        ADDIEX = 4'd11,
        ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    state_t state_d;

    logic funct_ok;

    always_comb begin
        funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                   (funct == FN_OR)  || (funct == FN_SLT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d     = FETCH;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUCtrl     = 3'b000;
        illegal     = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                // PC + 4 through the ALU while the IR loads from memory
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                ALUCtrl = ALU_ADD;
                PCWrite = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                // Speculatively compute the branch target PC + (imm << 2)
                ALUSrcB = 2'b11;
                ALUCtrl = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            state_d = EXEC;
                        end else begin
                            state_d = FETCH;
                            illegal = 1'b1;
                        end
                    end
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUCtrl = ALU_ADD;
                state_d = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = FETCH;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                case (funct)
                    FN_ADD:  ALUCtrl = ALU_ADD;
                    FN_SUB:  ALUCtrl = ALU_SUB;
                    FN_AND:  ALUCtrl = ALU_AND;
                    FN_OR:   ALUCtrl = ALU_OR;
                    FN_SLT:  ALUCtrl = ALU_SLT;
                    default: ALUCtrl = ALU_AND;
                endcase
                state_d = RWB;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                // Datapath gates the PC with PCWriteCond & zero
                ALUSrcA     = 1'b1;
                ALUCtrl     = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = FETCH;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUCtrl = ALU_ADD;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            default: begin
                // Unused encodings: outputs stay 0, recover to FETCH
                state_d = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multi_ctrl.sv
// Testbench for multi_ctrl: directed instruction sequences with
// hand-computed per-state control words.
module tb_multi_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       IRWrite, MemRead, MemWrite, IorD, MemtoReg, RegDst, RegWrite;
    logic       ALUSrcA, PCWrite, PCWriteCond;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUCtrl;
    logic       illegal;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    multi_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
        .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUCtrl(ALUCtrl),
        .illegal(illegal), .state(state)
    );

    // {IRWrite,MemRead,MemWrite,IorD,MemtoReg,RegDst,RegWrite,ALUSrcA,PCWrite,PCWriteCond,
    //  ALUSrcB[1:0],PCSource[1:0],ALUCtrl[2:0],illegal}
    logic [17:0] ctrl;
    assign ctrl = {IRWrite, MemRead, MemWrite, IorD, MemtoReg, RegDst, RegWrite,
                   ALUSrcA, PCWrite, PCWriteCond, ALUSrcB, PCSource, ALUCtrl, illegal};

    localparam logic [17:0] C_IDLE   = 18'b0000000000_00_00_000_0;
    localparam logic [17:0] C_FETCH  = 18'b1100000010_01_00_010_0;
    localparam logic [17:0] C_DECODE = 18'b0000000000_11_00_010_0;
    localparam logic [17:0] C_DECILL = 18'b0000000000_11_00_010_1;
    localparam logic [17:0] C_MEMADR = 18'b0000000100_10_00_010_0;
    localparam logic [17:0] C_MEMRD  = 18'b0101000000_00_00_000_0;
    localparam logic [17:0] C_MEMWB  = 18'b0000101000_00_00_000_0;
    localparam logic [17:0] C_MEMWR  = 18'b0011000000_00_00_000_0;
    localparam logic [17:0] C_EXSUB  = 18'b0000000100_00_00_110_0;
    localparam logic [17:0] C_EXOR   = 18'b0000000100_00_00_001_0;
    localparam logic [17:0] C_RWB    = 18'b0000011000_00_00_000_0;
    localparam logic [17:0] C_BRANCH = 18'b0000000101_00_01_110_0;
    localparam logic [17:0] C_JUMP   = 18'b0000000010_00_10_000_0;
    localparam logic [17:0] C_ADDIWB = 18'b0000001000_00_00_000_0;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                           S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
                           S_RWB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_ADDIEX = 4'd11,
                           S_ADDIWB = 4'd12;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        op    = 6'b0;
        funct = 6'b0;
        #2;
        total++;
        if (state !== S_IDLE || ctrl !== C_IDLE) begin
            bad++;
            $display("FAIL reset_hold: state=%0d ctrl=%b required state=%0d ctrl=%b",
                     state, ctrl, S_IDLE, C_IDLE);
        end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (state !== S_IDLE || ctrl !== C_IDLE) begin
            bad++;
            $display("FAIL reset_release_idle: state=%0d ctrl=%b required state=%0d ctrl=%b",
                     state, ctrl, S_IDLE, C_IDLE);
        end
        tick();
        total++;
        if (state !== S_FETCH || ctrl !== C_FETCH) begin
            bad++;
            $display("FAIL reset_first_fetch: state=%0d ctrl=%b required state=%0d ctrl=%b",
                     state, ctrl, S_FETCH, C_FETCH);
        end
    endtask

    // Each instruction task starts sampled in FETCH and ends sampled in the next FETCH.
    task automatic test_lw();
        logic [3:0]  st [6] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_FETCH};
        logic [17:0] cw [6] = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB, C_FETCH};
        op = 6'b100011; funct = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            total++;
            if (state !== st[i] || ctrl !== cw[i]) begin
                bad++;
                $display("FAIL lw step%0d: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         i, state, ctrl, st[i], cw[i]);
            end
        end
    endtask

    task automatic test_sw();
        logic [3:0]  st [5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_FETCH};
        logic [17:0] cw [5] = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMWR, C_FETCH};
        op = 6'b101011; funct = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            total++;
            if (state !== st[i] || ctrl !== cw[i]) begin
                bad++;
                $display("FAIL sw step%0d: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         i, state, ctrl, st[i], cw[i]);
            end
        end
    endtask

    task automatic test_rtype(input logic [5:0] fn, input logic [17:0] exec_cw);
        logic [3:0]  st [5] = '{S_FETCH, S_DECODE, S_EXEC, S_RWB, S_FETCH};
        logic [17:0] cw [5];
        cw = '{C_FETCH, C_DECODE, exec_cw, C_RWB, C_FETCH};
        op = 6'b000000; funct = fn;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            total++;
            if (state !== st[i] || ctrl !== cw[i]) begin
                bad++;
                $display("FAIL rtype_%b step%0d: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         fn, i, state, ctrl, st[i], cw[i]);
            end
        end
    endtask

    task automatic test_addi();
        logic [3:0]  st [5] = '{S_FETCH, S_DECODE, S_ADDIEX, S_ADDIWB, S_FETCH};
        logic [17:0] cw [5] = '{C_FETCH, C_DECODE, C_MEMADR, C_ADDIWB, C_FETCH};
        op = 6'b001000; funct = 6'b111111;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            total++;
            if (state !== st[i] || ctrl !== cw[i]) begin
                bad++;
                $display("FAIL addi step%0d: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         i, state, ctrl, st[i], cw[i]);
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [3:0]  stb [4] = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
        logic [17:0] cwb [4] = '{C_FETCH, C_DECODE, C_BRANCH, C_FETCH};
        logic [3:0]  stj [4] = '{S_FETCH, S_DECODE, S_JUMP, S_FETCH};
        logic [17:0] cwj [4] = '{C_FETCH, C_DECODE, C_JUMP, C_FETCH};
        op = 6'b000100; funct = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            total++;
            if (state !== stb[i] || ctrl !== cwb[i]) begin
                bad++;
                $display("FAIL beq step%0d: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         i, state, ctrl, stb[i], cwb[i]);
            end
        end
        op = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            total++;
            if (state !== stj[i] || ctrl !== cwj[i]) begin
                bad++;
                $display("FAIL j step%0d: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         i, state, ctrl, stj[i], cwj[i]);
            end
        end
    endtask

    task automatic test_illegal(input logic [5:0] o, input logic [5:0] fn);
        logic [3:0]  st [3] = '{S_FETCH, S_DECODE, S_FETCH};
        logic [17:0] cw [3] = '{C_FETCH, C_DECILL, C_FETCH};
        op = o; funct = fn;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            total++;
            if (state !== st[i] || ctrl !== cw[i]) begin
                bad++;
                $display("FAIL illegal_%b_%b step%0d: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         o, fn, i, state, ctrl, st[i], cw[i]);
            end
        end
    endtask

    task automatic test_async_abort();
        op = 6'b101011; funct = 6'b000000;
        tick();
        tick();
        tick();
        total++;
        if (state !== S_MEMWR || MemWrite !== 1'b1) begin
            bad++;
            $display("FAIL abort_in_memwr: state=%0d MemWrite=%b required state=%0d MemWrite=1",
                     state, MemWrite, S_MEMWR);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (state !== S_IDLE || ctrl !== C_IDLE) begin
            bad++;
            $display("FAIL abort_immediate: state=%0d ctrl=%b required state=%0d ctrl=%b",
                     state, ctrl, S_IDLE, C_IDLE);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (state !== S_IDLE || ctrl !== C_IDLE) begin
                bad++;
                $display("FAIL abort_hold%0d: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         i, state, ctrl, S_IDLE, C_IDLE);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (state !== S_FETCH || ctrl !== C_FETCH) begin
            bad++;
            $display("FAIL abort_refetch: state=%0d ctrl=%b required state=%0d ctrl=%b",
                     state, ctrl, S_FETCH, C_FETCH);
        end
    endtask

    // Mutual-exclusion watch across the whole run
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if ((MemRead && MemWrite) || (RegWrite && MemWrite)) begin
                bad++;
                $display("FAIL mem_reg_exclusive: MemRead=%b MemWrite=%b RegWrite=%b required no overlap",
                         MemRead, MemWrite, RegWrite);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: run time exceeded required bound");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype(6'b100010, C_EXSUB);
        test_rtype(6'b100101, C_EXOR);
        test_addi();
        test_branch_jump();
        test_illegal(6'b111111, 6'b100000);
        test_illegal(6'b000000, 6'b000001);
        test_lw();
        test_async_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
